// File: rtl/shot_seq_pkg.sv
// Shared types and default sizing for the multi-shot core sequencer.
package shot_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_GAP,
    S_FLUSH
  } state_t;

  localparam int NPROC_DEF         = 4;
  localparam int SHOTCNT_WIDTH_DEF = 32;
  localparam int DELAY_WIDTH_DEF   = 24;
  localparam int TIMEOUT_WIDTH_DEF = 27;
  localparam int RSTLEN_DEF        = 2;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shot_seq_if.sv
// Host/core-side signal bundle of the shot sequencer.
interface shot_seq_if #(
  parameter int NPROC         = 4,
  parameter int SHOTCNT_WIDTH = 32,
  parameter int DELAY_WIDTH   = 24,
  parameter int TIMEOUT_WIDTH = 27
);
  logic                     stb_start;
  logic                     stb_abort;
  logic [SHOTCNT_WIDTH-1:0] nshot;
  logic [DELAY_WIDTH-1:0]   shot_delay;
  logic [NPROC-1:0]         proc_mask;
  logic [TIMEOUT_WIDTH-1:0] timeout;
  logic [NPROC-1:0]         procend;
  logic [NPROC-1:0]         proc_reset;
  logic [NPROC-1:0]         shotstatus;
  logic [SHOTCNT_WIDTH-1:0] shotcnt;
  logic                     busy;
  logic                     stb_shotstart;
  logic                     stb_shotdone;
  logic                     lastshotdone;
  logic                     timeout_err;

  modport master (
    output stb_start, stb_abort, nshot, shot_delay, proc_mask, timeout, procend,
    input  proc_reset, shotstatus, shotcnt, busy, stb_shotstart, stb_shotdone,
           lastshotdone, timeout_err
  );

  modport slave (
    input  stb_start, stb_abort, nshot, shot_delay, proc_mask, timeout, procend,
    output proc_reset, shotstatus, shotcnt, busy, stb_shotstart, stb_shotdone,
           lastshotdone, timeout_err
  );
endinterface

// File: rtl/shot_seq_timer.sv
// Loadable saturating down-counter shared by the RST, GAP, FLUSH and timeout phases.
module shot_seq_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/shot_seq.sv
// Multi-shot sequencer: resets enabled cores, waits for end-of-shot, repeats with
// optional gap; supports continuous mode, run timeout and abort.
module shot_seq
  import shot_seq_pkg::*;
#(
  parameter int NPROC         = NPROC_DEF,
  parameter int SHOTCNT_WIDTH = SHOTCNT_WIDTH_DEF,
  parameter int DELAY_WIDTH   = DELAY_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF,
  parameter int RSTLEN        = RSTLEN_DEF
) (
  input logic       clk,
  input logic       reset_n,
  shot_seq_if.slave bus
);
  localparam int TMR_W = imax(imax(DELAY_WIDTH, TIMEOUT_WIDTH), $clog2(RSTLEN) + 1);

  state_t state, state_d;

  logic [NPROC-1:0]         mask_q, mask_d;
  logic [SHOTCNT_WIDTH-1:0] nshot_q;
  logic [DELAY_WIDTH-1:0]   delay_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_q;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  logic [NPROC-1:0]         proc_reset_q, proc_reset_d;
  logic [NPROC-1:0]         shotstatus_q, shotstatus_d;
  logic [SHOTCNT_WIDTH-1:0] shotcnt_q, shotcnt_d, cnt_inc;
  logic busy_q, shotstart_q, shotdone_q, last_q, tmo_err_q;
  logic last_d, tmo_err_d;

  logic start_ok, abort_ok, done, done_take, final_shot, tmo, tmo_take;

  assign start_ok   = (state == S_IDLE) && bus.stb_start && (|bus.proc_mask);
  assign abort_ok   = bus.stb_abort && (state == S_RST || state == S_RUN || state == S_GAP);
  assign done       = (state == S_RUN) && (&(shotstatus_q | ~mask_q));
  assign cnt_inc    = shotcnt_q + 1'b1;
  assign final_shot = (nshot_q != '0) && (cnt_inc == nshot_q);
  assign tmo        = (state == S_RUN) && (timeout_q != '0) && tmr_zero;
  // Priority: abort > completion > timeout.
  assign done_take  = done && !abort_ok;
  assign tmo_take   = tmo && !done && !abort_ok;
  assign mask_d     = start_ok ? bus.proc_mask : mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start_ok) state_d = S_RST;
      S_RST: begin
        if (abort_ok)      state_d = S_FLUSH;
        else if (tmr_zero) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_ok)                state_d = S_FLUSH;
        else if (done_take) begin
          if (final_shot)            state_d = S_IDLE;
          else if (delay_q == '0)    state_d = S_RST;
          else                       state_d = S_GAP;
        end else if (tmo_take)       state_d = S_FLUSH;
      end
      S_GAP: begin
        if (abort_ok)      state_d = S_FLUSH;
        else if (tmr_zero) state_d = S_RST;
      end
      S_FLUSH: if (tmr_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Timer reloads on every state change with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_d != state);
    tmr_dec  = !tmr_load;
    case (state_d)
      S_RST, S_FLUSH: tmr_val = TMR_W'(RSTLEN - 1);
      S_RUN:          tmr_val = TMR_W'(timeout_q);
      S_GAP:          tmr_val = TMR_W'(delay_q - 1'b1);
      default:        tmr_val = '0;
    endcase

    proc_reset_d = (state_d == S_RST || state_d == S_FLUSH) ? mask_d : '0;

    // The first RUN cycle is blanked so stale end-of-shot levels are not counted.
    if (state_d == S_RST)                        shotstatus_d = '0;
    else if (state == S_RUN && !shotstart_q)     shotstatus_d = shotstatus_q | (bus.procend & mask_q);
    else                                         shotstatus_d = shotstatus_q;

    shotcnt_d = shotcnt_q;
    last_d    = last_q;
    tmo_err_d = tmo_err_q;
    if (start_ok) begin
      shotcnt_d = '0;
      last_d    = 1'b0;
      tmo_err_d = 1'b0;
    end else begin
      if (done_take)               shotcnt_d = cnt_inc;
      if (done_take && final_shot) last_d    = 1'b1;
      if (tmo_take)                tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '0;
      nshot_q      <= '0;
      delay_q      <= '0;
      timeout_q    <= '0;
      proc_reset_q <= '0;
      shotstatus_q <= '0;
      shotcnt_q    <= '0;
      busy_q       <= 1'b0;
      shotstart_q  <= 1'b0;
      shotdone_q   <= 1'b0;
      last_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        nshot_q   <= bus.nshot;
        delay_q   <= bus.shot_delay;
        timeout_q <= bus.timeout;
      end
      mask_q       <= mask_d;
      proc_reset_q <= proc_reset_d;
      shotstatus_q <= shotstatus_d;
      shotcnt_q    <= shotcnt_d;
      busy_q       <= (state_d != S_IDLE);
      shotstart_q  <= (state_d == S_RUN) && (state != S_RUN);
      shotdone_q   <= done_take;
      last_q       <= last_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  shot_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign bus.proc_reset    = proc_reset_q;
  assign bus.shotstatus    = shotstatus_q;
  assign bus.shotcnt       = shotcnt_q;
  assign bus.busy          = busy_q;
  assign bus.stb_shotstart = shotstart_q;
  assign bus.stb_shotdone  = shotdone_q;
  assign bus.lastshotdone  = last_q;
  assign bus.timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_shot_seq.sv
// Directed bench for shot_seq with a small core model and a shotcnt scoreboard.
module tb_shot_seq;
  localparam int NP = 4, SW = 32, DW = 24, TW = 27, RL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shot_seq_if #(.NPROC(NP), .SHOTCNT_WIDTH(SW), .DELAY_WIDTH(DW), .TIMEOUT_WIDTH(TW)) bus();

  shot_seq #(.NPROC(NP), .SHOTCNT_WIDTH(SW), .DELAY_WIDTH(DW), .TIMEOUT_WIDTH(TW), .RSTLEN(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  logic          model_en = 1'b1;
  logic [NP-1:0] alive    = '1;
  logic [NP-1:0] model_pe = '0;
  logic [NP-1:0] man_pe   = '0;
  int            run_cnt  = -1;

  assign bus.procend = model_en ? model_pe : man_pe;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: live cores raise procend 10 cycles after RUN entry, drop it under reset.
  always @(negedge clk) begin
    if (!reset_n || bus.proc_reset != '0) begin
      model_pe = '0;
      run_cnt  = -1;
    end else if (bus.stb_shotstart) begin
      run_cnt = 0;
    end else if (run_cnt >= 0) begin
      run_cnt++;
      if (run_cnt == 10) model_pe = alive;
    end
  end

  // Scoreboard: every completed shot must match the next expected shotcnt.
  always @(negedge clk) begin
    if (reset_n && bus.stb_shotdone) begin
      if (exp_q.size() == 0) check("unexpected_shotdone", 64'(bus.stb_shotdone), 64'd0);
      else                   check("shotcnt_at_done", 64'(bus.shotcnt), 64'(exp_q.pop_front()));
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return !bus.busy;
      1:       return bus.stb_shotstart;
      2:       return bus.lastshotdone;
      default: return bus.shotcnt == 3;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int bound);
    int n = 0;
    while (!cond(sel) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(cond(sel)), 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [NP-1:0] m, input int unsigned ns,
                       input int unsigned dl, input int unsigned to);
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    d = dl[DW-1:0];
    t = to[TW-1:0];
    bus.proc_mask  = m;
    bus.nshot      = ns;
    bus.shot_delay = d;
    bus.timeout    = t;
    bus.stb_start  = 1'b1;
    @(negedge clk);
    bus.stb_start  = 1'b0;
  endtask

  initial begin
    bus.stb_start = 1'b0; bus.stb_abort = 1'b0; bus.nshot = '0;
    bus.shot_delay = '0;  bus.proc_mask = '0;   bus.timeout = '0;

    // Reset state and ignored zero-mask start
    step(2);
    check("rst_outputs", 64'({bus.proc_reset, bus.shotstatus, bus.busy, bus.stb_shotstart,
                              bus.stb_shotdone, bus.lastshotdone, bus.timeout_err}), 64'd0);
    check("rst_shotcnt", 64'(bus.shotcnt), 64'd0);
    reset_n = 1'b1;
    step(1);
    start(4'b0000, 1, 0, 0);
    check("zero_mask_ignored", 64'(bus.busy), 64'd0);

    // Three shots, no gap
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    start(4'b1111, 3, 0, 0);
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_rst", 64'(bus.proc_reset), 64'hF);
    step(1);
    check("rst_hold", 64'(bus.proc_reset), 64'hF);
    step(1);
    check("run_rst_low", 64'(bus.proc_reset), 64'h0);
    check("run_shotstart", 64'(bus.stb_shotstart), 64'd1);
    wait_until("t1_last_wait", 2, 200);
    check("t1_busy_fall", 64'(bus.busy), 64'd0);
    check("t1_last_pulse", 64'(bus.stb_shotdone), 64'd1);
    check("t1_cnt", 64'(bus.shotcnt), 64'd3);

    // Partial mask: cores 1 and 3 never finish
    alive = 4'b0101;
    exp_q.push_back(1);
    start(4'b0101, 1, 0, 0);
    check("t2_rst_mask", 64'(bus.proc_reset), 64'h5);
    wait_until("t2_last_wait", 2, 100);
    check("t2_status", 64'(bus.shotstatus), 64'h5);
    check("t2_busy", 64'(bus.busy), 64'd0);

    // Continuous mode with gap, aborted inside a gap
    alive = 4'b1111;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    start(4'b1111, 0, 5, 0);
    wait_until("t3_cnt3_wait", 3, 300);
    step(1);
    check("t3_gap_quiet", 64'({bus.busy, bus.proc_reset}), 64'h10);
    bus.stb_abort = 1'b1;
    @(negedge clk);
    bus.stb_abort = 1'b0;
    check("t3_flush1", 64'(bus.proc_reset), 64'hF);
    step(1);
    check("t3_flush2", 64'(bus.proc_reset), 64'hF);
    step(1);
    check("t3_flush_end", 64'({bus.busy, bus.proc_reset}), 64'h0);
    check("t3_cnt_held", 64'(bus.shotcnt), 64'd3);
    check("t3_not_last", 64'(bus.lastshotdone), 64'd0);

    // Timeout: core 2 never ends, T=20
    alive = 4'b1011;
    start(4'b1111, 1, 0, 20);
    wait_until("t4_run_wait", 1, 20);
    step(20);
    check("t4_no_tmo_yet", 64'({bus.timeout_err, bus.busy}), 64'h1);
    step(1);
    check("t4_tmo_set", 64'(bus.timeout_err), 64'd1);
    check("t4_flush", 64'(bus.proc_reset), 64'hF);
    step(2);
    check("t4_idle", 64'(bus.busy), 64'd0);
    check("t4_no_last", 64'({bus.lastshotdone, bus.timeout_err}), 64'h1);

    // Abort in the completion cycle; start while busy ignored
    alive = 4'b1111;
    model_en = 1'b0;
    man_pe = '0;
    start(4'b1111, 1, 0, 0);
    wait_until("t5_run_wait", 1, 20);
    start(4'b0011, 1, 0, 0);
    step(2);
    man_pe = 4'b1111;
    @(negedge clk);
    check("t5_status_full", 64'(bus.shotstatus), 64'hF);
    bus.stb_abort = 1'b1;
    @(negedge clk);
    bus.stb_abort = 1'b0;
    check("t5_no_done", 64'(bus.stb_shotdone), 64'd0);
    check("t5_flush_mask", 64'(bus.proc_reset), 64'hF);
    check("t5_cnt", 64'(bus.shotcnt), 64'd0);
    step(2);
    check("t5_idle", 64'(bus.busy), 64'd0);
    man_pe = '0;
    model_en = 1'b1;

    // Asynchronous reset mid-run, then a clean run
    start(4'b1111, 1, 0, 0);
    wait_until("t6_run_wait", 1, 20);
    step(3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_outputs", 64'({bus.proc_reset, bus.shotstatus, bus.busy, bus.stb_shotstart,
                                   bus.stb_shotdone, bus.lastshotdone, bus.timeout_err}), 64'd0);
    check("t6_async_cnt", 64'(bus.shotcnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    exp_q.push_back(1);
    start(4'b1111, 1, 0, 0);
    wait_until("t6_last_wait", 2, 100);
    check("t6_cnt", 64'(bus.shotcnt), 64'd1);
    step(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
